// File: rtl/fft16_pkg.sv
// Shared constants, FSM state encoding and bit-reverse helper for the 16-point FFT sequencer.
package fft16_pkg;
  localparam int N      = 16;
  localparam int LOG2N  = 4;
  localparam int ADDR_W = 4;
  localparam int TW_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BITREV,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  function automatic logic [ADDR_W-1:0] bitrev4(input logic [ADDR_W-1:0] i);
    return {i[0], i[1], i[2], i[3]};
  endfunction
endpackage

// File: rtl/fft16_addr_gen.sv
// Radix-2 DIT butterfly address/twiddle generator: (stage, k) -> operand pair and W16 index.
module fft16_addr_gen
  import fft16_pkg::*;
(
  input  logic [1:0]        stage_i,
  input  logic [2:0]        k_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic [TW_W-1:0]   tw_idx_o
);
  // A zero is inserted at bit position 'stage' of k to form the top address.
  always_comb begin
    addr_a_o = '0;
    tw_idx_o = '0;
    case (stage_i)
      2'd0: begin addr_a_o = {k_i, 1'b0};                  tw_idx_o = '0;                end
      2'd1: begin addr_a_o = {k_i[2:1], 1'b0, k_i[0]};     tw_idx_o = {k_i[0], 2'b00};   end
      2'd2: begin addr_a_o = {k_i[2], 1'b0, k_i[1:0]};     tw_idx_o = {k_i[1:0], 1'b0};  end
      default: begin addr_a_o = {1'b0, k_i};               tw_idx_o = k_i;               end
    endcase
  end

  assign addr_b_o = addr_a_o | (4'd1 << stage_i);
endmodule

// File: rtl/fft16_stage_sequencer.sv
// Stage/butterfly sequencer for the iterative 16-point FFT/IFFT datapath.
// Optional FFT_SEQ_BITREV_EN adds a 16-cycle bit-reverse reorder pass before stage 0.
module fft16_stage_sequencer
  import fft16_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  output logic              busy,
  output logic              bf_valid,
  output logic [ADDR_W-1:0] bf_addr_a,
  output logic [ADDR_W-1:0] bf_addr_b,
  output logic [TW_W-1:0]   bf_tw_idx,
  output logic              bf_conj,
  output logic [1:0]        stage,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr_a,
  output logic [ADDR_W-1:0] wb_addr_b,
  output logic              done
);
  localparam logic [3:0] DRAIN_LAST = 4'(BF_LAT - 1);

  seq_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] stage_q, stage_d;
  logic       conj_q, conj_d;
  logic       flush;

  logic [ADDR_W-1:0] ga, gb;
  logic [TW_W-1:0]   gtw;

  fft16_addr_gen u_addr (
    .stage_i  (stage_q),
    .k_i      (cnt_q[2:0]),
    .addr_a_o (ga),
    .addr_b_o (gb),
    .tw_idx_o (gtw)
  );

  assign flush = abort && (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      conj_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      conj_q  <= conj_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    conj_d  = conj_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      stage_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start && !abort) begin
          conj_d  = mode;
          cnt_d   = '0;
          stage_d = '0;
`ifdef FFT_SEQ_BITREV_EN
          state_d = S_BITREV;
`else
          state_d = S_ISSUE;
`endif
        end
        S_BITREV: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            cnt_d   = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end
        end
        // Drain lets every in-flight write land before the next stage reads.
        S_DRAIN: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == DRAIN_LAST) begin
            cnt_d = '0;
            if (stage_q == 2'd3) begin
              state_d = S_DONE;
            end else begin
              stage_d = stage_q + 2'd1;
              state_d = S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          stage_d = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bf_valid  = (state_q == S_ISSUE);
  assign bf_addr_a = bf_valid ? ga  : '0;
  assign bf_addr_b = bf_valid ? gb  : '0;
  assign bf_tw_idx = bf_valid ? gtw : '0;
  assign bf_conj   = conj_q;
  assign stage     = stage_q;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_BITREV);
  assign done      = (state_q == S_DONE);

  // Write-back delay line: slot BF_LAT holds the issue from BF_LAT cycles ago.
  logic [BF_LAT:1]             vld_pipe_q;
  logic [BF_LAT:1][ADDR_W-1:0] a_pipe_q, b_pipe_q;
  logic [BF_LAT:0]             vld_ext;
  logic [BF_LAT:0][ADDR_W-1:0] a_ext, b_ext;

  assign vld_ext = {vld_pipe_q, bf_valid};
  assign a_ext   = {a_pipe_q, bf_addr_a};
  assign b_ext   = {b_pipe_q, bf_addr_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      a_pipe_q   <= '0;
      b_pipe_q   <= '0;
    end else if (flush) begin
      vld_pipe_q <= '0;
      a_pipe_q   <= '0;
      b_pipe_q   <= '0;
    end else begin
      vld_pipe_q <= vld_ext[BF_LAT-1:0];
      a_pipe_q   <= a_ext[BF_LAT-1:0];
      b_pipe_q   <= b_ext[BF_LAT-1:0];
    end
  end

  always_comb begin
    wb_valid  = vld_pipe_q[BF_LAT];
    wb_addr_a = a_pipe_q[BF_LAT];
    wb_addr_b = b_pipe_q[BF_LAT];
`ifdef FFT_SEQ_BITREV_EN
    if (state_q == S_BITREV) begin
      wb_valid  = 1'b1;
      wb_addr_a = cnt_q;
      wb_addr_b = bitrev4(cnt_q);
    end
`endif
  end
endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Scoreboard bench for fft16_stage_sequencer: issue/write-back order, timing, abort, reset.
module tb_fft16_stage_sequencer;
  localparam int BF_LAT = 2;
`ifdef FFT_SEQ_BITREV_EN
  localparam int BR = 16;
`else
  localparam int BR = 0;
`endif
  localparam int LAST = 4 * (8 + BF_LAT) + BR;

  logic clk = 0, rst = 0, start = 0, mode = 0, abort = 0;
  logic busy, bf_valid, bf_conj, wb_valid, done;
  logic [3:0] bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b;
  logic [2:0] bf_tw_idx;
  logic [1:0] stage;

  fft16_stage_sequencer #(.BF_LAT(BF_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .bf_tw_idx(bf_tw_idx), .bf_conj(bf_conj), .stage(stage), .wb_valid(wb_valid),
    .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] a, b; logic [2:0] tw; logic cj; logic [1:0] st; int due; } bf_e_t;
  typedef struct { logic [3:0] a, b; int due; logic [1:0] st; } wb_e_t;

  bf_e_t bfq[$];
  wb_e_t wbq[$];
  int ecnt = 0, base = 0, mcyc = 0, n_cmp = 0, n_err = 0;
  logic run_active = 0, run_done = 0;
  logic [25:0] outs;

  assign outs = {busy, bf_valid, bf_addr_a, bf_addr_b, bf_tw_idx, bf_conj, stage,
                 wb_valid, wb_addr_a, wb_addr_b, done};

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] brv(input logic [3:0] x);
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = x[3-j];
    return r;
  endfunction

  task automatic do_start(input logic m);
    bf_e_t e;
    int half, pos, a;
    start = 1; mode = m; base = ecnt;
    run_active = 1; run_done = 0;
    for (int i = 0; i < BR; i++) wbq.push_back('{4'(i), brv(4'(i)), i + 1, 2'd0});
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++) begin
        half = 1 << s;
        pos  = k & (half - 1);
        a    = (k >> s) * 2 * half + pos;
        e.a = 4'(a); e.b = 4'(a + half); e.tw = 3'(pos << (3 - s));
        e.cj = m; e.st = 2'(s); e.due = 1 + BR + s * (8 + BF_LAT) + k;
        bfq.push_back(e);
      end
  endtask

  task automatic wait_cyc(input int c);
    for (int i = 0; i < 1000 && (ecnt - base) < c; i++) @(negedge clk);
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !run_done; i++) @(negedge clk);
    #1;
    chk("done_seen", 32'(run_done), 1);
    chk("bfq_empty", bfq.size(), 0);
    chk("wbq_empty", wbq.size(), 0);
  endtask

  task automatic clear_sb();
    bfq.delete(); wbq.delete(); run_active = 0;
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard as the DUT produces output.
  always @(negedge clk) begin
    bf_e_t be;
    wb_e_t we;
    if (!rst) begin
      mcyc = ecnt - base;
      if (run_active) chk("busy", 32'(busy), 32'(mcyc >= 1 && mcyc <= LAST));
      if (wbq.size() > 0 && wbq[0].due < mcyc) begin
        chk("wb_missed", mcyc, wbq[0].due);
        void'(wbq.pop_front());
      end
      if (wb_valid) begin
        if (wbq.size() == 0) chk("wb_spurious", 1, 0);
        else begin
          we = wbq.pop_front();
          chk("wb", {8'h0, wb_addr_a, wb_addr_b, 16'(mcyc)}, {8'h0, we.a, we.b, 16'(we.due)});
        end
      end
      if (bf_valid) begin
        if (bfq.size() == 0) chk("bf_spurious", 1, 0);
        else begin
          be = bfq.pop_front();
          chk("bf", {2'b0, bf_addr_a, bf_addr_b, bf_tw_idx, bf_conj, stage, 16'(mcyc)},
                    {2'b0, be.a, be.b, be.tw, be.cj, be.st, 16'(be.due)});
          if (wbq.size() > 0) chk("rw_overlap", 32'(wbq[0].st), 32'(stage));
          wbq.push_back('{bf_addr_a, bf_addr_b, mcyc + BF_LAT, stage});
        end
      end
      if (done) begin
        chk("done_cyc", run_active ? mcyc : -1, LAST + 1);
        run_active = 0;
        run_done = 1;
      end
    end
  end

  initial begin
    #2 rst = 1;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs), 0);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", 32'(outs), 0);
    end
    #1;

    // Plain FFT run.
    do_start(0);
    wait_cyc(1); start = 0;
    wait_done();

    // IFFT run; mid-run start/mode toggle and start coincident with done are ignored.
    wait_cyc(LAST + 5);
    do_start(1);
    wait_cyc(1); start = 0;
    wait_cyc(20); start = 1; mode = 0;
    wait_cyc(21); start = 0;
    wait_cyc(LAST + 1); start = 1;
    wait_cyc(LAST + 2);
    chk("start_at_done_busy", 32'(busy), 0);
    chk("start_at_done_bf", 32'(bf_valid), 0);
    start = 0;
    chk("ifft_done", 32'(run_done), 1);
    chk("ifft_bfq_empty", bfq.size(), 0);

    // Abort mid-run, then abort+start in IDLE, then a fresh run.
    wait_cyc(LAST + 6);
    do_start(0);
    wait_cyc(1); start = 0;
    wait_cyc(15); abort = 1; clear_sb();
    wait_cyc(16);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_wb", 32'(wb_valid), 0);
    chk("abort_bf", 32'(bf_valid), 0);
    abort = 0;
    wait_cyc(LAST + 20);
    chk("abort_no_done", 32'(run_done), 0);
    start = 1; abort = 1;
    wait_cyc(LAST + 21);
    start = 0; abort = 0;
    wait_cyc(LAST + 23);
    chk("abort_idle_busy", 32'(busy), 0);
    do_start(0);
    wait_cyc(1); start = 0;
    wait_done();

    // Reset mid-run.
    wait_cyc(LAST + 5);
    do_start(0);
    wait_cyc(1); start = 0;
    wait_cyc(10);
    rst = 1; clear_sb();
    #2;
    chk("rst_mid_outs", 32'(outs), 0);
    @(negedge clk); #1 rst = 0;
    wait_cyc(LAST + 20);
    chk("rst_no_done", 32'(run_done), 0);
    chk("rst_idle_outs", 32'(outs), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
